// File: rtl/window_gen_kxk.sv
// K x K sliding-window generator: K-1 line buffers feed a K x K register window,
// followed by a border pad mux and an output register stage (2-cycle latency).
module window_gen_kxk #(
    parameter int DW         = 8,
    parameter int K          = 3,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PAD_MODE   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                video_vs,
    input  logic                video_de,
    input  logic [DW-1:0]       video_data,
    output logic                win_de,
    output logic [K*K*DW-1:0]   win_data,
    output logic                win_full,
    output logic [10:0]         win_x,
    output logic [10:0]         win_y
);

    localparam int          AW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [10:0] X_LAST = 11'(IMG_WIDTH - 1);
    localparam logic [10:0] Y_LAST = 11'(IMG_HEIGHT - 1);
    localparam logic [10:0] KM1    = 11'(K - 1);

    logic                vs_q;
    logic                vs_rise_s;
    logic [10:0]         x_q, x_d, y_q, y_d;
    logic [10:0]         px_s, py_s;
    logic [AW-1:0]       addr_s;
    logic [DW-1:0]       col_s   [K];
    logic [DW-1:0]       lb_mem  [K-1][IMG_WIDTH];
    logic [DW-1:0]       win1_q  [K][K];
    logic                s1_vld_q;
    logic [10:0]         s1_x_q, s1_y_q;
    logic [K*K*DW-1:0]   win_data_d;
    logic                win_full_d;
    logic                win_de_q;
    logic [K*K*DW-1:0]   win_data_q;
    logic                win_full_q;
    logic [10:0]         win_x_q, win_y_q;

    // Position of the current pixel (a vs rising edge restarts at 0,0) and counter advance
    always_comb begin
        vs_rise_s = video_vs & ~vs_q;
        if (vs_rise_s) begin
            px_s = 11'd0;
            py_s = 11'd0;
        end else begin
            px_s = x_q;
            py_s = y_q;
        end
        x_d = px_s;
        y_d = py_s;
        if (video_de) begin
            if (px_s == X_LAST) begin
                x_d = 11'd0;
                if (py_s == Y_LAST) begin
                    y_d = 11'd0;
                end else begin
                    y_d = py_s + 11'd1;
                end
            end else begin
                x_d = px_s + 11'd1;
                y_d = py_s;
            end
        end else begin
            x_d = px_s;
            y_d = py_s;
        end
    end

    assign addr_s = px_s[AW-1:0];

    // Newest window column: one pixel per buffered line plus the incoming pixel at the bottom
    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            col_s[r] = lb_mem[r][addr_s];
        end
        col_s[K-1] = video_data;
    end

    // Line buffers: each accepted pixel pushes column x one line up the chain
    always_ff @(posedge clk) begin
        if (video_de) begin
            for (int r = 0; r < K - 1; r++) begin
                lb_mem[r][addr_s] <= col_s[r + 1];
            end
        end
    end

    // Stage 1: counters, vs edge detect and the raw K x K window shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q     <= 1'b0;
            x_q      <= 11'd0;
            y_q      <= 11'd0;
            s1_vld_q <= 1'b0;
            s1_x_q   <= 11'd0;
            s1_y_q   <= 11'd0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win1_q[r][c] <= '0;
                end
            end
        end else begin
            vs_q     <= video_vs;
            x_q      <= x_d;
            y_q      <= y_d;
            s1_vld_q <= video_de;
            if (video_de) begin
                s1_x_q <= px_s;
                s1_y_q <= py_s;
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) begin
                        win1_q[r][c] <= win1_q[r][c + 1];
                    end
                    win1_q[r][K-1] <= col_s[r];
                end
            end
        end
    end

    // Stage 2: out-of-image elements never come from the raw window; zero or clamp to the edge
    always_comb begin
        logic row_ok;
        logic col_ok;
        int   rs;
        int   cs;
        win_data_d = '0;
        win_full_d = (s1_y_q >= KM1) && (s1_x_q >= KM1);
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                row_ok = ({1'b0, s1_y_q} + 12'(r)) >= 12'(K - 1);
                col_ok = ({1'b0, s1_x_q} + 12'(c)) >= 12'(K - 1);
                rs     = row_ok ? r : (K - 1 - int'(s1_y_q));
                cs     = col_ok ? c : (K - 1 - int'(s1_x_q));
                if (PAD_MODE == 0) begin
                    if (row_ok && col_ok) begin
                        win_data_d[(r*K+c)*DW +: DW] = win1_q[r][c];
                    end else begin
                        win_data_d[(r*K+c)*DW +: DW] = '0;
                    end
                end else begin
                    win_data_d[(r*K+c)*DW +: DW] = win1_q[rs][cs];
                end
            end
        end
    end

    // Output register: data and coordinates hold while no window is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_de_q   <= 1'b0;
            win_data_q <= '0;
            win_full_q <= 1'b0;
            win_x_q    <= 11'd0;
            win_y_q    <= 11'd0;
        end else begin
            win_de_q <= s1_vld_q;
            if (s1_vld_q) begin
                win_data_q <= win_data_d;
                win_full_q <= win_full_d;
                win_x_q    <= s1_x_q;
                win_y_q    <= s1_y_q;
            end else begin
                win_data_q <= win_data_q;
                win_full_q <= win_full_q;
                win_x_q    <= win_x_q;
                win_y_q    <= win_y_q;
            end
        end
    end

    assign win_de   = win_de_q;
    assign win_data = win_data_q;
    assign win_full = win_full_q;
    assign win_x    = win_x_q;
    assign win_y    = win_y_q;

endmodule

// File: tb/tb_window_gen_kxk.sv
// Bench for window_gen_kxk: an image-array model predicts every window, plus literal spot checks.
module tb_window_gen_kxk;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vs_a, de_a, vs_b, de_b;
    logic [7:0]  data_a;
    logic [9:0]  data_b;

    logic        a0_de, a0_f, a1_de, a1_f, b_de, b_f;
    logic [71:0] a0_d, a1_d;
    logic [249:0] b_d;
    logic [10:0] a0_x, a0_y, a1_x, a1_y, b_x, b_y;

    window_gen_kxk #(.DW(8), .K(3), .IMG_WIDTH(5), .IMG_HEIGHT(5), .PAD_MODE(0)) u_a0 (
        .clk(clk), .rst_n(rst_n), .video_vs(vs_a), .video_de(de_a), .video_data(data_a),
        .win_de(a0_de), .win_data(a0_d), .win_full(a0_f), .win_x(a0_x), .win_y(a0_y));
    window_gen_kxk #(.DW(8), .K(3), .IMG_WIDTH(5), .IMG_HEIGHT(5), .PAD_MODE(1)) u_a1 (
        .clk(clk), .rst_n(rst_n), .video_vs(vs_a), .video_de(de_a), .video_data(data_a),
        .win_de(a1_de), .win_data(a1_d), .win_full(a1_f), .win_x(a1_x), .win_y(a1_y));
    window_gen_kxk #(.DW(10), .K(5), .IMG_WIDTH(7), .IMG_HEIGHT(7), .PAD_MODE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .video_vs(vs_b), .video_de(de_b), .video_data(data_b),
        .win_de(b_de), .win_data(b_d), .win_full(b_f), .win_x(b_x), .win_y(b_y));

    typedef struct {
        logic [249:0] d;
        logic         f;
        int           x;
        int           y;
        int           due;
    } exp_t;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    exp_t         expq [3][$];
    int           img [7][7];
    int           mx = 0;
    int           my = 0;
    bit           pvs [2];
    int           decnt [3];
    logic [249:0] cap_d [3][7][7];
    logic         cap_f [3][7][7];
    logic [249:0] last_d [3];
    logic         last_f [3];
    int           last_x [3];
    int           last_y [3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [249:0] got, input logic [249:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    // Window straight from the image: element (r,c) = p[y-(k-1)+r][x-(k-1)+c] with padding
    function automatic logic [249:0] exp_win(input int k, input int dw, input int pad,
                                             input int x, input int y);
        logic [249:0] v;
        int ry, cx, e;
        v = '0;
        for (int r = 0; r < k; r++) begin
            for (int c = 0; c < k; c++) begin
                ry = y - (k - 1) + r;
                cx = x - (k - 1) + c;
                if ((ry < 0 || cx < 0) && pad == 0) e = 0;
                else e = img[(ry < 0) ? 0 : ry][(cx < 0) ? 0 : cx];
                v = v | (250'(e) << ((r * k + c) * dw));
            end
        end
        return v;
    endfunction

    function automatic logic [249:0] pk3(input int a, input int b, input int c, input int d,
                                         input int e, input int f, input int g, input int h,
                                         input int i);
        int vals [9];
        logic [249:0] v;
        vals = '{a, b, c, d, e, f, g, h, i};
        v = '0;
        for (int n = 0; n < 9; n++) v = v | (250'(vals[n]) << (n * 8));
        return v;
    endfunction

    task automatic model_step(input int s, input bit vs, input bit de, input int val);
        exp_t e;
        int w, k;
        w = (s == 0) ? 5 : 7;
        k = (s == 0) ? 3 : 5;
        if (vs && !pvs[s]) begin
            mx = 0;
            my = 0;
        end
        pvs[s] = vs;
        if (de) begin
            img[my][mx] = val;
            e.f = (mx >= k - 1) && (my >= k - 1);
            e.x = mx;
            e.y = my;
            e.due = cyc + 2;
            if (s == 0) begin
                e.d = exp_win(3, 8, 0, mx, my);
                expq[0].push_back(e);
                e.d = exp_win(3, 8, 1, mx, my);
                expq[1].push_back(e);
            end else begin
                e.d = exp_win(5, 10, 0, mx, my);
                expq[2].push_back(e);
            end
            if (mx == w - 1) begin
                mx = 0;
                my = (my == w - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end
    endtask

    task automatic px(input int s, input bit vs, input bit de, input int val);
        @(posedge clk);
        #1;
        if (s == 0) begin
            vs_a = vs; de_a = de; data_a = 8'(val);
        end else begin
            vs_b = vs; de_b = de; data_b = 10'(val);
        end
        model_step(s, vs, de, val);
    endtask

    task automatic check_dut(input int id, input logic de, input logic [249:0] d, input logic f,
                             input logic [10:0] x, input logic [10:0] y);
        logic exp_de;
        exp_t e;
        exp_de = (expq[id].size() > 0) ? (expq[id][0].due <= cyc) : 1'b0;
        total++;
        if (de !== exp_de) begin
            bad++;
            $display("FAIL win_de dut%0d cyc=%0d got=%0b want=%0b", id, cyc, de, exp_de);
        end
        if (exp_de) begin
            e = expq[id].pop_front();
            if (de === 1'b1) begin
                total++;
                if (d !== e.d || f !== e.f || int'(x) != e.x || int'(y) != e.y) begin
                    bad++;
                    $display("FAIL window dut%0d got x=%0d y=%0d full=%0b data=%0h want x=%0d y=%0d full=%0b data=%0h",
                             id, x, y, f, d, e.x, e.y, e.f, e.d);
                end
            end
        end
        if (de === 1'b1) begin
            decnt[id]++;
            last_d[id] = d;
            last_f[id] = f;
            last_x[id] = int'(x);
            last_y[id] = int'(y);
            if (x < 11'd7 && y < 11'd7) begin
                cap_d[id][y][x] = d;
                cap_f[id][y][x] = f;
            end
        end
    endtask

    always @(negedge clk) begin
        check_dut(0, a0_de, {178'd0, a0_d}, a0_f, a0_x, a0_y);
        check_dut(1, a1_de, {178'd0, a1_d}, a1_f, a1_x, a1_y);
        check_dut(2, b_de, b_d, b_f, b_x, b_y);
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_a0_de"}, 250'(a0_de), 250'd0);
        chk({tag, "_a0_data"}, 250'(a0_d), 250'd0);
        chk({tag, "_a0_full"}, 250'(a0_f), 250'd0);
        chk({tag, "_a0_x"}, 250'(a0_x), 250'd0);
        chk({tag, "_a0_y"}, 250'(a0_y), 250'd0);
        chk({tag, "_b_de"}, 250'(b_de), 250'd0);
        chk({tag, "_b_data"}, b_d, 250'd0);
    endtask

    task automatic idle(input int s, input int n);
        for (int i = 0; i < n; i++) px(s, 1'b0, 1'b0, 0);
    endtask

    initial begin
        logic [249:0] w44, w34;
        rst_n = 1'b0;
        vs_a = 1'b0; de_a = 1'b0; data_a = 8'd0;
        vs_b = 1'b0; de_b = 1'b0; data_b = 10'd0;
        #2;
        chk_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Continuous frame, vs edge coincident with the first pixel
        px(0, 1'b1, 1'b1, 1);
        for (int i = 1; i < 25; i++) px(0, 1'b0, 1'b1, i + 1);
        idle(0, 4);
        chk("model_2_2", exp_win(3, 8, 0, 2, 2), pk3(1, 2, 3, 6, 7, 8, 11, 12, 13));
        chk("zero_2_2", cap_d[0][2][2], pk3(1, 2, 3, 6, 7, 8, 11, 12, 13));
        chk("zero_2_2_full", 250'(cap_f[0][2][2]), 250'd1);
        chk("zero_1_1", cap_d[0][1][1], pk3(0, 0, 0, 0, 1, 2, 0, 6, 7));
        chk("zero_1_1_full", 250'(cap_f[0][1][1]), 250'd0);
        chk("repl_1_1", cap_d[1][1][1], pk3(1, 1, 2, 1, 1, 2, 6, 6, 7));
        chk("repl_0_3", cap_d[1][3][0], pk3(6, 6, 6, 11, 11, 11, 16, 16, 16));

        // Gapped frame: counters wrapped to 0,0, same data every other cycle
        decnt[0] = 0;
        for (int i = 0; i < 25; i++) begin
            px(0, 1'b0, 1'b1, i + 1);
            px(0, 1'b0, 1'b0, 0);
        end
        idle(0, 4);
        chk("gap_count", 250'(decnt[0]), 250'd25);
        chk("gap_zero_2_2", cap_d[0][2][2], pk3(1, 2, 3, 6, 7, 8, 11, 12, 13));

        // Resync after 7 pixels of a new frame with different data
        for (int i = 0; i < 7; i++) px(0, 1'b0, 1'b1, 100 + i);
        px(0, 1'b1, 1'b0, 0);
        px(0, 1'b0, 1'b1, 150);
        idle(0, 3);
        chk("resync_x", 250'(last_x[0]), 250'd0);
        chk("resync_y", 250'(last_y[0]), 250'd0);
        chk("resync_zero", last_d[0], pk3(0, 0, 0, 0, 0, 0, 0, 0, 150));
        chk("resync_repl", last_d[1], pk3(150, 150, 150, 150, 150, 150, 150, 150, 150));
        chk("resync_full", 250'(last_f[0]), 250'd0);
        for (int i = 1; i < 10; i++) px(0, 1'b0, 1'b1, 150 + i);
        idle(0, 3);

        // Reset while windows are still in the pipeline
        px(0, 1'b0, 1'b1, 77);
        px(0, 1'b0, 1'b1, 78);
        @(posedge clk);
        #1;
        de_a = 1'b0;
        rst_n = 1'b0;
        for (int q = 0; q < 3; q++) expq[q].delete();
        mx = 0;
        my = 0;
        pvs[0] = 1'b0;
        pvs[1] = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        px(0, 1'b0, 1'b1, 200);
        idle(0, 3);
        chk("rst_first_x", 250'(last_x[0]), 250'd0);
        chk("rst_first_y", 250'(last_y[0]), 250'd0);
        chk("rst_first_zero", last_d[0], pk3(0, 0, 0, 0, 0, 0, 0, 0, 200));
        chk("rst_first_repl", last_d[1], pk3(200, 200, 200, 200, 200, 200, 200, 200, 200));

        // K=5, DW=10, 7x7 zero-padded frame
        px(1, 1'b1, 1'b1, 1);
        for (int i = 1; i < 49; i++) px(1, 1'b0, 1'b1, i + 1);
        idle(1, 4);
        w44 = '0;
        w34 = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                w44 = w44 | (250'(r * 7 + c + 1) << ((r * 5 + c) * 10));
                if (c > 0) w34 = w34 | (250'(r * 7 + c) << ((r * 5 + c) * 10));
            end
        end
        chk("model_k5_4_4", exp_win(5, 10, 0, 4, 4), w44);
        chk("k5_4_4", cap_d[2][4][4], w44);
        chk("k5_4_4_full", 250'(cap_f[2][4][4]), 250'd1);
        chk("k5_3_4", cap_d[2][4][3], w34);
        chk("k5_3_4_full", 250'(cap_f[2][4][3]), 250'd0);

        for (int q = 0; q < 3; q++) chk("pending_windows", 250'(expq[q].size()), 250'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
